// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus between the fetch unit, instruction memory, the
// hazard/branch logic and the decode stage.
//   master (fetch unit): drives imem_addr and the registered fetch outputs,
//                        receives imem_instr, stall and the redirect request.
//   slave  (environment): the opposite direction of every signal.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic        halt_oor;
    logic [31:0] fetch_count;
    modport master (
        output imem_addr, instr_out, pc_out, instr_valid, halted, halt_oor, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, instr_out, pc_out, instr_valid, halted, halt_oor, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and fetch register for a single-cycle
// RISC-V core with a combinational instruction memory.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_unit_if.master: imem_addr/imem_instr memory port,
//          stall and redirect inputs, registered instr_out/pc_out/instr_valid,
//          halted/halt_oor status and fetch_count.
// Optional feature: define FETCH_COUNT_EN to implement the fetch counter;
// otherwise fetch_count reads as zero.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_DEPTH = 32'd32,
    parameter logic [31:0] SENTINEL   = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_halted;
    logic        r_oor;
    logic [31:0] w_target;
    logic        w_oor;
    logic        w_sent;
    assign w_target = bus.redirect_pc & ~32'd3;
    assign w_oor    = {2'b00, r_pc[31:2]} >= IMEM_DEPTH;
    assign w_sent   = bus.imem_instr == SENTINEL;
    assign bus.imem_addr   = {2'b00, r_pc[31:2]};
    assign bus.instr_out   = r_instr;
    assign bus.pc_out      = r_pc_out;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.halt_oor    = r_oor;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC & ~32'd3;
            r_instr  <= NOP;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_oor    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.redirect_valid)
                        r_pc <= w_target;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // Redirect wins over stall and halt; stall defers the halt checks.
                    if (bus.redirect_valid) begin
                        r_pc    <= w_target;
                        r_instr <= NOP;
                        r_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        if (w_oor || w_sent) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                            r_oor    <= w_oor;
                            r_valid  <= 1'b0;
                            r_instr  <= NOP;
                            r_pc_out <= r_pc;
                        end else begin
                            r_instr  <= bus.imem_instr;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_pc     <= r_pc + 32'd4;
                        end
                    end
                end
                S_HALTED: begin
                    if (bus.redirect_valid) begin
                        r_pc     <= w_target;
                        r_halted <= 1'b0;
                        r_oor    <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`ifdef FETCH_COUNT_EN
    logic        w_fire;
    logic [31:0] r_fetch_count;
    // Counts exactly the edges that latch a valid instruction.
    assign w_fire = r_state == S_FETCH && !bus.redirect_valid && !bus.stall && !w_oor && !w_sent;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fetch_count <= '0;
        else if (w_fire)
            r_fetch_count <= r_fetch_count + 32'd1;
    end
    assign bus.fetch_count = r_fetch_count;
`else
    assign bus.fetch_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized stall/redirect
// traffic, checked every cycle against a behavioural fetch model.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 8;
    localparam logic [31:0] SENT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk;
    logic rst;
    logic [31:0] mem [DEPTH];
    int n_checks;
    int n_fail;
    logic [31:0] m_pc, m_instr, m_pcout, m_cnt;
    bit m_valid, m_halted, m_oor, m_idle;
    instr_fetch_unit_if bus();
    instr_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always_comb bus.imem_instr = (bus.imem_addr < DEPTH) ? mem[bus.imem_addr[2:0]] : 32'h0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] rnd_word();
        return $urandom & 32'h7FFF_FFFF;
    endfunction
    function automatic logic [31:0] mem_at(input logic [31:0] pc);
        return (pc / 4 < DEPTH) ? mem[pc / 4] : 32'h0;
    endfunction
    task automatic model_step(input bit s, input bit rv, input logic [31:0] rpc);
        logic [31:0] ins;
        ins = mem_at(m_pc);
        if (m_idle) begin
            if (rv) m_pc = rpc & ~32'd3;
            m_idle = 0;
        end else if (m_halted) begin
            if (rv) begin
                m_pc = rpc & ~32'd3;
                m_halted = 0;
                m_oor = 0;
            end
        end else if (rv) begin
            m_pc = rpc & ~32'd3;
            m_instr = NOP;
            m_valid = 0;
        end else if (!s) begin
            if (m_pc / 4 >= DEPTH || ins == SENT) begin
                m_halted = 1;
                m_oor = (m_pc / 4 >= DEPTH);
                m_valid = 0;
                m_instr = NOP;
                m_pcout = m_pc;
            end else begin
                m_instr = ins;
                m_pcout = m_pc;
                m_valid = 1;
                m_pc = m_pc + 4;
                m_cnt = m_cnt + 1;
            end
        end
    endtask
    task automatic compare_all();
        check("instr_out", bus.instr_out, m_instr);
        check("pc_out", bus.pc_out, m_pcout);
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("halt_oor", 32'(bus.halt_oor), 32'(m_oor));
        check("fetch_count", bus.fetch_count, CNT_EN ? m_cnt : 32'h0);
    endtask
    task automatic cycle(input bit s, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.stall = s;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        #1;
        check("imem_addr", bus.imem_addr, m_pc / 4);
        model_step(s, rv, rpc);
        @(posedge clk);
        #1;
        compare_all();
    endtask
    // Asserts reset away from any clock edge, checks the immediate reset
    // values, then releases it just after a rising edge.
    task automatic do_reset();
        bus.stall = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc = 0;
        rst = 1;
        #1;
        check("rst_instr", bus.instr_out, NOP);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_oor", 32'(bus.halt_oor), 32'h0);
        check("rst_count", bus.fetch_count, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        m_pc = 0; m_instr = NOP; m_pcout = 0; m_cnt = 0;
        m_valid = 0; m_halted = 0; m_oor = 0; m_idle = 1;
        @(posedge clk);
        #2 rst = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 0;
        bus.stall = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc = 0;
        // Straight-line program ending in the sentinel.
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd_word();
        mem[3] = SENT;
        #3;
        do_reset();
        repeat (5) cycle(0, 0, 0);
        check("sl_halted", 32'(bus.halted), 32'h1);
        check("sl_oor", 32'(bus.halt_oor), 32'h0);
        check("sl_pc_out", bus.pc_out, 32'd12);
        check("sl_count", bus.fetch_count, CNT_EN ? 32'd3 : 32'd0);
        // Stall on the sentinel, redirect racing it, restart from HALTED.
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd_word();
        mem[1] = SENT;
        mem[5] = SENT;
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("st_halted", 32'(bus.halted), 32'h0);
        check("st_addr", bus.imem_addr, 32'd1);
        check("st_pc_out", bus.pc_out, 32'd0);
        cycle(0, 1, 32'h13);
        check("rd_valid", 32'(bus.instr_valid), 32'h0);
        check("rd_instr", bus.instr_out, NOP);
        check("rd_halted", 32'(bus.halted), 32'h0);
        cycle(0, 0, 0);
        check("rd_pc_out", bus.pc_out, 32'h10);
        check("rd_valid2", 32'(bus.instr_valid), 32'h1);
        cycle(0, 0, 0);
        check("s5_halted", 32'(bus.halted), 32'h1);
        check("s5_pc_out", bus.pc_out, 32'h14);
        cycle(1, 0, 0);
        cycle(0, 1, 32'd8);
        check("rs_halted", 32'(bus.halted), 32'h0);
        check("rs_oor", 32'(bus.halt_oor), 32'h0);
        cycle(0, 0, 0);
        check("rs_pc_out", bus.pc_out, 32'd8);
        check("rs_instr", bus.instr_out, mem[2]);
        // Out-of-range halt with no sentinel anywhere.
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd_word();
        do_reset();
        repeat (DEPTH + 2) cycle(0, 0, 0);
        check("oor_halted", 32'(bus.halted), 32'h1);
        check("oor_oor", 32'(bus.halt_oor), 32'h1);
        check("oor_pc_out", bus.pc_out, DEPTH * 4);
        // Asynchronous reset in the middle of a run.
        do_reset();
        repeat (4) cycle(0, 0, 0);
        #3;
        do_reset();
        cycle(0, 0, 0);
        check("mr_idle_valid", 32'(bus.instr_valid), 32'h0);
        cycle(0, 0, 0);
        check("mr_pc_out", bus.pc_out, 32'h0);
        check("mr_valid", 32'(bus.instr_valid), 32'h1);
        // Randomized traffic against the model.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = ($urandom_range(0, 11) == 0) ? SENT : rnd_word();
            for (int c = 0; c < 150; c++)
                cycle($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                      32'($urandom_range(0, DEPTH * 4 + 12)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the single-cycle RISC-V core's instruction memory. It owns the program counter and drives the word address into the combinational instruction memory. It registers the returned word together with its PC for the decode stage. It honours stall and branch/jump redirects, and halts when the memory returns the all-ones end-of-program sentinel or the PC leaves the populated memory range.

## Interface
- `RESET_PC`, 32'h0000_0000, byte PC loaded on reset; low 2 bits ignored
- `IMEM_DEPTH`, 32, number of 32-bit words in instruction memory
- `SENTINEL`, 32'hFFFF_FFFF, instruction word meaning "end of program"
- `NOP`, 32'h0000_0013, word placed on `instr_out` when no valid instruction (addi x0,x0,0)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_addr`  out  32  word index into instruction memory = `{2'b00, pc[31:2]}`, combinational from PC register
- `imem_instr`  in  32  word returned combinationally by instruction memory for `imem_addr`
- `stall`  in  1  hold PC and output register this cycle
- `redirect_valid`  in  1  load new PC (branch/jump taken)
- `redirect_pc`  in  32  target byte address; bits [1:0] forced to 0
- `instr_out`  out  32  registered fetched instruction
- `pc_out`  out  32  registered byte PC of `instr_out`
- `instr_valid`  out  1  `instr_out` is a real instruction
- `halted`  out  1  fetch stopped (sentinel or out-of-range)
- `halt_oor`  out  1  halt cause was out-of-range PC (0 = sentinel)
- `fetch_count`  out  32  number of instructions delivered with `instr_valid=1` (see Configuration)

## Operation
- State machine: IDLE, FETCH, HALTED.
- Reset values:
  - pc=`RESET_PC` & ~3
  - state=IDLE
  - `instr_out`=`NOP`, `pc_out`=0
  - `instr_valid`=0, `halted`=0, `halt_oor`=0, `fetch_count`=0
- IDLE:
  - One bubble cycle after reset release, then FETCH.
  - If `redirect_valid` is asserted in IDLE, pc loads the target and the next state is FETCH.
- FETCH, evaluated each edge in priority order:
  1. `redirect_valid`: pc ← `redirect_pc` & ~3; `instr_out`←`NOP`; `instr_valid`←0. Stays FETCH. Redirect overrides stall and halt.
  2. `stall`: all registers hold, including `fetch_count`. Sentinel and range checks are deferred until stall drops.
  3. pc[31:2] ≥ `IMEM_DEPTH`: state←HALTED; `halted`←1; `halt_oor`←1; `instr_valid`←0; `instr_out`←`NOP`; `pc_out`←pc.
  4. `imem_instr` == `SENTINEL`: same as rule 3, but `halt_oor`←0.
  5. Otherwise: `instr_out`←`imem_instr`; `pc_out`←pc; `instr_valid`←1; pc←pc+4; `fetch_count`++.
- HALTED:
  - pc and outputs frozen; `imem_addr` stays at the halting word.
  - `redirect_valid` restarts fetch: pc←target, `halted`←0, `halt_oor`←0, state←FETCH.
  - `stall` has no effect.
- Arithmetic: pc+4 is 32-bit and wraps 32'hFFFF_FFFC→0. In practice the range check halts first for any `IMEM_DEPTH` < 2^30.

## Timing
- Fetch latency: PC presented on `imem_addr` in cycle n appears on `instr_out`/`pc_out` after edge n+1.
- Steady-state throughput: 1 instruction/cycle.
- Redirect cost:
  - Redirect sampled at edge n gives `instr_valid`=0 after edge n (one bubble).
  - The target instruction is valid after edge n+1.
- `halted` rises at the same edge that would have latched the sentinel. `instr_valid` falls at that edge.
- Async reset mid-operation: all outputs take reset values immediately, without waiting for a clock edge. Fetch resumes from `RESET_PC` after the IDLE cycle.

## Configuration
- `FETCH_COUNT_EN` defined: the 32-bit `fetch_count` register is implemented and updated as above. It wraps modulo 2^32.
- `FETCH_COUNT_EN` undefined: no counter logic; `fetch_count` is tied to 32'h0. All other behaviour is identical.

## Test plan
- Straight-line program: memory holds 3 instructions at words 0–2, then `SENTINEL`; no stall. Required response:
  - `pc_out` 0,4,8 with `instr_valid`=1 on three consecutive cycles.
  - Then `halted`=1, `halt_oor`=0, `pc_out`=12.
  - `fetch_count`=3 when enabled.
- Stall on a sentinel: hold `stall`=1 for 2 cycles while `imem_addr`=1. Required response:
  - Outputs and `imem_addr` hold.
  - `fetch_count` unchanged.
  - No halt occurs while the sentinel sits on the bus under stall.
- Redirect racing the sentinel: assert `redirect_valid` with `redirect_pc`=32'h0000_0013 in the same cycle the sentinel is on the bus. Required response:
  - No halt.
  - One bubble (`instr_valid`=0, `instr_out`=`NOP`).
  - Next `pc_out`=32'h10.
- Out-of-range halt: `IMEM_DEPTH`=4, no sentinel. Required response: after words 0–3, `halted`=1, `halt_oor`=1, `pc_out`=16.
- Restart from HALTED: in HALTED, apply `redirect_pc`=8. Required response:
  - `halted`/`halt_oor` clear at that edge.
  - Word 2 is valid on the following edge.
- Mid-run reset: assert `rst` asynchronously mid-run. Required response:
  - `instr_valid`=0, `pc_out`=0, `fetch_count`=0 before the next edge.
  - After release: one IDLE cycle, then fetch from `RESET_PC`.
